// File: rtl/mult8_dot_accumulator.sv
// mult8_dot_accumulator
// Registered, flow-controlled dot-product stage around an 8x8 unsigned
// multiplier. Operand pairs are registered (stage 1), multiplied
// combinationally, and LEN consecutive products are summed (stage 2) into
// a saturating ACC_W-bit result presented on a valid/ready output.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous flush of partial sum, count and stage-1 valid
//   in_valid   operand pair present
//   in_ready   block can accept an operand pair this cycle
//   in_a/in_b  unsigned 8-bit operands
//   out_valid  result held on out_acc/out_sat
//   out_ready  downstream accepts the result
//   out_acc    saturated dot-product result (ACC_W bits)
//   out_sat    saturation occurred while forming this result

// Combinational 8x8 unsigned shift-and-add multiplier.
module multiplier_8bits_version14 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  // Sum of a_i shifted by every set bit position of b_i.
  always_comb begin
    p_o = 16'd0;
    for (int i = 0; i < 8; i++) begin
      if (b_i[i]) begin
        p_o = p_o + (16'(a_i) << i);
      end else begin
        p_o = p_o;
      end
    end
  end

endmodule

module mult8_dot_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat
);

  localparam int         SUM_W    = ACC_W + 1;
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             v1_q, v1_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic             out_sat_q, out_sat_d;
  logic             out_valid_q, out_valid_d;
  logic             rdy_q;

  logic             en_s;
  logic [15:0]      prod_s;
  logic [SUM_W-1:0] base_s;
  logic [SUM_W-1:0] sum_s;

  // The whole pipeline stalls only while a finished result waits downstream.
  assign en_s      = !(out_valid_q && !out_ready);
  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_q && en_s;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_sat   = out_sat_q;

  multiplier_8bits_version14 u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod_s)
  );

  // Running sum one bit wider than the result; the first element of a
  // group ignores the stale accumulator.
  always_comb begin
    base_s = (cnt_q == 8'd0) ? {SUM_W{1'b0}} : {1'b0, acc_q};
    sum_s  = base_s + {{(SUM_W-16){1'b0}}, prod_s};
  end

  // Next-state logic for operand, accumulate and result registers.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    v1_d      = v1_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_sat_d = out_sat_q;

    // A consumed result drops valid unless a new one loads below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (clr) begin
      // Flush the group in flight; a finished result is left untouched.
      v1_d  = 1'b0;
      cnt_d = 8'd0;
      sat_d = 1'b0;
      acc_d = {ACC_W{1'b0}};
    end else if (en_s) begin
      a_d  = in_a;
      b_d  = in_b;
      v1_d = in_valid && in_ready;
      if (v1_q) begin
        // Top bit set means the sum reached 2^ACC_W; clamp and stick.
        if (sum_s[SUM_W-1]) begin
          acc_d = {ACC_W{1'b1}};
          sat_d = 1'b1;
        end else begin
          acc_d = sum_s[ACC_W-1:0];
          sat_d = (cnt_q == 8'd0) ? 1'b0 : sat_q;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d       = 8'd0;
          out_acc_d   = acc_d;
          out_sat_d   = sat_d;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      v1_q        <= 1'b0;
      cnt_q       <= 8'd0;
      acc_q       <= {ACC_W{1'b0}};
      sat_q       <= 1'b0;
      out_acc_q   <= {ACC_W{1'b0}};
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_acc_q   <= out_acc_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult8_dot_accumulator.sv
// Testbench for mult8_dot_accumulator: three instances sharing one input
// stream (LEN=4/ACC_W=24, LEN=4/ACC_W=17, LEN=1/ACC_W=24), each with its
// own reference model and result scoreboard.
module tb_mult8_dot_accumulator;

  typedef struct packed {
    logic [31:0] acc;
    logic        sat;
  } res_t;

  typedef struct {
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    logic [31:0] e24;
    logic        s24;
    logic [31:0] e17;
    logic        s17;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_sat   [3];
  logic [31:0] out_acc   [3];
  logic        up_r;
  logic        drain_chk = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Marks that at least one edge has passed since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) up_r <= 1'b0;
    else        up_r <= 1'b1;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 1) ? 17 : 24;
    localparam int L = (g == 2) ? 1 : 4;
    logic [W-1:0] acc_loc;

    mult8_dot_accumulator #(.ACC_W(W), .LEN(L)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_acc   (acc_loc),
      .out_sat   (out_sat[g])
    );
    assign out_acc[g] = 32'(acc_loc);

    // Reference model: one pending accepted pair, an exact group sum, and
    // a queue of expected results in order.
    res_t        q[$];
    res_t        r;
    longint      sum;
    int          cnt;
    bit          pv;
    longint      pp;
    bit          hv;
    logic [31:0] ha;
    logic        hs;
    bit          en;

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        sum = 0; cnt = 0; pv = 1'b0; hv = 1'b0;
      end else begin
        en = !(out_valid[g] && !out_ready);
        if (up_r) chk($sformatf("dut%0d in_ready", g), in_ready[g], en);
        if (hv) begin
          chk($sformatf("dut%0d held valid", g), out_valid[g], 1'b1);
          chk($sformatf("dut%0d held acc", g), out_acc[g], ha);
          chk($sformatf("dut%0d held sat", g), out_sat[g], hs);
        end
        hv = out_valid[g] && !out_ready;
        ha = out_acc[g];
        hs = out_sat[g];
        if (out_valid[g] && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected result actual=%0d expected=none", g, out_acc[g]);
          end else begin
            r = q.pop_front();
            chk($sformatf("dut%0d result acc", g), out_acc[g], r.acc);
            chk($sformatf("dut%0d result sat", g), out_sat[g], r.sat);
          end
        end
        if (clr) begin
          pv = 1'b0; cnt = 0; sum = 0;
        end else if (en) begin
          if (pv) begin
            sum = sum + pp;
            cnt = cnt + 1;
            if (cnt == L) begin
              if (sum >= (longint'(1) << W)) begin
                r.acc = 32'((longint'(1) << W) - 1);
                r.sat = 1'b1;
              end else begin
                r.acc = 32'(sum);
                r.sat = 1'b0;
              end
              q.push_back(r);
              cnt = 0; sum = 0;
            end
          end
          pv = in_valid && in_ready[g];
          pp = longint'(in_a) * longint'(in_b);
        end
        if (drain_chk) chk($sformatf("dut%0d leftover results", g), q.size(), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b1;
    step();
    clr = 1'b0;
    step();
    step();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_a = a; in_b = b;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t tbl [4];

  initial begin
    bit ok;
    tbl[0].a = '{8'd1, 8'd3, 8'd5, 8'd7};
    tbl[0].b = '{8'd2, 8'd4, 8'd6, 8'd8};
    tbl[0].e24 = 32'd100;    tbl[0].s24 = 1'b0; tbl[0].e17 = 32'd100;    tbl[0].s17 = 1'b0;
    tbl[1].a = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[1].b = '{8'd255, 8'd255, 8'd255, 8'd255};
    tbl[1].e24 = 32'd260100; tbl[1].s24 = 1'b0; tbl[1].e17 = 32'd131071; tbl[1].s17 = 1'b1;
    tbl[2].a = '{8'd0, 8'd0, 8'd0, 8'd0};
    tbl[2].b = '{8'd0, 8'd0, 8'd0, 8'd0};
    tbl[2].e24 = 32'd0;      tbl[2].s24 = 1'b0; tbl[2].e17 = 32'd0;      tbl[2].s17 = 1'b0;
    tbl[3].a = '{8'd1, 8'd1, 8'd1, 8'd1};
    tbl[3].b = '{8'd1, 8'd1, 8'd1, 8'd1};
    tbl[3].e24 = 32'd4;      tbl[3].s24 = 1'b0; tbl[3].e17 = 32'd4;      tbl[3].s17 = 1'b0;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 8'd0; in_b = 8'd0;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d reset in_ready", d), in_ready[d], 1'b0);
      chk($sformatf("dut%0d reset out_valid", d), out_valid[d], 1'b0);
      chk($sformatf("dut%0d reset out_acc", d), out_acc[d], 32'd0);
      chk($sformatf("dut%0d reset out_sat", d), out_sat[d], 1'b0);
    end
    #20 rst_n = 1'b1;
    step();
    step();
    for (int d = 0; d < 3; d++) chk($sformatf("dut%0d in_ready after reset", d), in_ready[d], 1'b1);

    // Table: one group per record, out_ready high, single 2-cycle-late pulse.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1; in_a = tbl[t].a[k]; in_b = tbl[t].b[k];
        step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("tbl%0d dut%0d early valid", t, d), out_valid[d], 1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("tbl%0d dut%0d valid", t, d), out_valid[d], 1'b1);
        chk($sformatf("tbl%0d dut%0d acc", t, d), out_acc[d], (d == 1) ? tbl[t].e17 : tbl[t].e24);
        chk($sformatf("tbl%0d dut%0d sat", t, d), out_sat[d], (d == 1) ? tbl[t].s17 : tbl[t].s24);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk($sformatf("tbl%0d dut%0d pulse end", t, d), out_valid[d], 1'b0);
      @(posedge clk);
      #1;
    end

    // Backpressure on the LEN=1 instance.
    flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3; step();
    in_a = 8'd4; in_b = 8'd5; step();
    in_a = 8'd6; in_b = 8'd7; step();
    repeat (3) begin
      chk("bp held acc", out_acc[2], 32'd6);
      chk("bp in_ready low", in_ready[2], 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp second valid", out_valid[2], 1'b1);
    chk("bp second acc", out_acc[2], 32'd20);
    step();
    chk("bp third valid", out_valid[2], 1'b1);
    chk("bp third acc", out_acc[2], 32'd42);
    step();
    chk("bp drained", out_valid[2], 1'b0);

    // clr in the middle of a group.
    flush();
    send(8'd10, 8'd10, 2);
    clr = 1'b1; step(); clr = 1'b0;
    send(8'd1, 8'd1, 4);
    wait_valid(0, 8, ok);
    chk("clr result seen", ok, 1'b1);
    chk("clr result acc", out_acc[0], 32'd4);
    @(posedge clk); #1;

    // Asynchronous reset after three accepted pairs.
    flush();
    send(8'd3, 8'd3, 3);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d async out_valid", d), out_valid[d], 1'b0);
      chk($sformatf("dut%0d async out_acc", d), out_acc[d], 32'd0);
      chk($sformatf("dut%0d async out_sat", d), out_sat[d], 1'b0);
      chk($sformatf("dut%0d async in_ready", d), in_ready[d], 1'b0);
    end
    #10 rst_n = 1'b1;
    step();
    step();
    send(8'd2, 8'd2, 4);
    wait_valid(0, 8, ok);
    chk("post reset result seen", ok, 1'b1);
    chk("post reset acc", out_acc[0], 32'd16);
    @(posedge clk); #1;

    // Random traffic against the scoreboards.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom);
      in_b      = ($urandom_range(0, 2) == 0) ? 8'd255 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 59) == 0);
      step();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    drain_chk = 1'b1;
    @(negedge clk);
    #1 drain_chk = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult8_dot_accumulator.md
Name: mult8_dot_accumulator

Overview:
- Sequential consumer stage that wraps the team's 8x8 unsigned combinational multiplier (multiplier_8bits_version14) in a registered, flow-controlled pipeline.
- Accepts a stream of operand pairs and multiplies each pair. Accumulates LEN consecutive 16-bit products into one dot-product result.
- Presents the result on a valid/ready output with a saturation flag.
- Sits between an operand source (FIFO/DMA) and downstream filter/MAC logic.

Parameters:
- ACC_W, 24, accumulator and result width in bits; legal range 16..32.
- LEN, 4, number of products summed per result; legal range 1..255.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of partial sum, count and stage-1 valid.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  8  unsigned multiplicand.
- in_b  input  8  unsigned multiplier.
- out_valid  output  1  result held on out_acc/out_sat.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  dot-product result, saturated.
- out_sat  output  1  saturation occurred in this result.

Behaviour:
- Interface timing: one clock (clk). Reset (rst_n) is asynchronous, active-low. Reset deassertion is synchronised externally.
- Reset values: in_ready=0 while rst_n=0, then 1 from the first cycle after reset release. out_valid=0, out_acc=0, out_sat=0. Stage-1 valid=0, count=0, partial sum=0.
- Global enable: en = !(out_valid && !out_ready). in_ready = en. Stage 1 and stage 2 advance only when en=1; all pipeline state holds when en=0.
- Stage 1, operand registers: on en, a_q/b_q <= in_a/in_b and v1 <= in_valid&&in_ready.
- The multiplier is driven combinationally from a_q/b_q. Its product is 16 bits, zero-extended to ACC_W+1 bits.
- Stage 2, accumulate (on en && v1):
  - sum = (count==0 ? 0 : acc) + product, computed at ACC_W+1 bits.
  - If sum >= 2^ACC_W: acc <= 2^ACC_W-1 and sat_q <= 1.
  - Otherwise: acc <= sum, and sat_q <= (count==0 ? 0 : sat_q).
  - Once sat_q is set it stays sticky; the saturated acc is then re-added, so the result remains saturated.
  - count <= count+1, wrapping to 0 when count==LEN-1.
- Result load: on the stage-2 update where count==LEN-1:
  - out_acc <= saturated value, out_sat <= final sat flag, out_valid <= 1.
  - count returns to 0; the partial sum is discarded on the next first element.
- Output handshake: out_valid falls the cycle after out_valid && out_ready. If out_ready is high in the same cycle a new result loads, the new result replaces the old one and out_valid stays 1.
- out_acc/out_sat are stable while out_valid=1 && out_ready=0.
- Latency: last operand pair accepted in cycle t -> out_valid=1 in cycle t+2. Throughput is one pair per cycle when out_ready is held high.
- Backpressure: while a result is unconsumed, no operand is accepted and stage-1 contents are retained. No data is lost or duplicated.
- LEN=1: every accepted pair produces one result. Saturation is impossible for ACC_W>=16.
- clr (sampled at the clock, priority over en):
  - v1 <= 0, count <= 0, sat_q <= 0.
  - Does not affect an already-valid out_acc/out_valid.
  - in_ready is unchanged (still en); an operand presented with clr is dropped.
- Reset mid-operation: all state returns to reset values asynchronously. A partial dot-product is discarded; no spurious out_valid follows.
- FSM view (derived from count and out_valid):
  - FILL (count 0..LEN-1 and out_valid=0).
  - FULL_HOLD (out_valid=1, out_ready=0): stalled.
  - DRAIN (out_valid=1, out_ready=1): continues filling.

Test Plan:
- Basic: LEN=4, ACC_W=24, out_ready=1, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> single out_valid pulse 2 cycles after the 4th accept, out_acc=100, out_sat=0.
- Max operands: LEN=4, ACC_W=24, four pairs (255,255) -> out_acc=260100, out_sat=0. Next group (0,0)x4 -> out_acc=0, confirming the partial sum restarts per result.
- Saturation: LEN=4, ACC_W=17, four pairs (255,255) -> out_acc=131071, out_sat=1. Following group (1,1)x4 -> out_acc=4, out_sat=0.
- Backpressure: LEN=1, out_ready=0, stream (2,3),(4,5),(6,7) -> out_acc=6 held and in_ready=0 until out_ready rises. Then results 20 and 42 follow in order with no loss or duplication.
- clr mid-group: LEN=4, accept (10,10),(10,10), assert clr one cycle, then (1,1)x4 -> out_acc=4. No result contains 200.
- Async reset: LEN=4, assert rst_n=0 mid-cycle after 3 accepted pairs -> all outputs 0 immediately. After release, (2,2)x4 -> out_acc=16.
